// File: rtl/regfile_wport_arb.sv
// regfile_wport_arb
//   Shares the single write port of the 32x32 register file between the
//   writeback stage (A, absolute priority, never back-pressured) and a
//   long-latency unit (B, valid/ready) whose results are buffered in a small
//   in-order queue. Also reports pending buffered writes to decode read
//   addresses for hazard stalls.
//
//   Optional feature macro: RF_ARB_AGE_EN
//     defined   : head-age counter saturating at AGE_LIMIT drives stall_req
//     undefined : no counter, stall_req tied to 0, AGE_LIMIT ignored
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   a_we/a_waddr/a_wdata    writeback request (r0 writes discarded)
//   b_valid/b_ready/b_waddr/b_wdata  long-unit result handshake
//   we/waddr/wdata      register file write port
//   q1_addr/q2_addr     decode read addresses
//   q1_hit/q2_hit       a pending long-unit write targets the query address
//   stall_req           request a writeback bubble (aged head)
//   occupancy           number of queue entries
module regfile_wport_arb #(
    parameter int DEPTH     = 2,
    parameter int AGE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_we,
    input  logic [4:0]             a_waddr,
    input  logic [31:0]            a_wdata,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [4:0]             b_waddr,
    input  logic [31:0]            b_wdata,
    output logic                   we,
    output logic [4:0]             waddr,
    output logic [31:0]            wdata,
    input  logic [4:0]             q1_addr,
    input  logic [4:0]             q2_addr,
    output logic                   q1_hit,
    output logic                   q2_hit,
    output logic                   stall_req,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0 || AGE_LIMIT < 0) begin : g_param_check
        $error("regfile_wport_arb: DEPTH must be a power of two in 2..8");
    end

    logic          q_valid [DEPTH];
    logic [4:0]    q_addr  [DEPTH];
    logic [31:0]   q_data  [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic a_eff;
    logic nonempty;
    logic head_live;
    logic head_grant;
    logic pop;
    logic space;
    logic push;
    logic push_live;
    logic q1_match;
    logic q2_match;

    always_comb begin
        a_eff      = a_we && (a_waddr != 5'd0);
        nonempty   = (count != '0);
        head_live  = nonempty && q_valid[head];
        head_grant = head_live && !a_eff;
        // A dead (killed or r0) head leaves regardless of A and never drives we.
        pop        = nonempty && (!q_valid[head] || head_grant);
        space      = (count < CW'(DEPTH));
        push       = b_valid && space;
        // A same-cycle writeback to the same register is younger: store dead.
        push_live  = (b_waddr != 5'd0) && !(a_eff && (a_waddr == b_waddr));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_valid[PW'(i)] <= 1'b0;
                q_addr[PW'(i)]  <= '0;
                q_data[PW'(i)]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (a_eff && (q_addr[PW'(i)] == a_waddr)) begin
                    q_valid[PW'(i)] <= 1'b0;
                end
            end
            // Popped slots are invalidated so that valid bits outside the
            // occupied region stay 0 and the hazard search can scan all slots.
            if (pop) begin
                q_valid[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            if (push) begin
                q_valid[tail] <= push_live;
                q_addr[tail]  <= b_waddr;
                q_data[tail]  <= b_wdata;
                tail          <= tail + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (!rst) begin
            if (a_eff) begin
                we    = 1'b1;
                waddr = a_waddr;
                wdata = a_wdata;
            end else if (head_live) begin
                we    = 1'b1;
                waddr = q_addr[head];
                wdata = q_data[head];
            end
        end
    end

    always_comb begin
        q1_match = 1'b0;
        q2_match = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (q_valid[PW'(i)] && (q_addr[PW'(i)] == q1_addr)) q1_match = 1'b1;
            if (q_valid[PW'(i)] && (q_addr[PW'(i)] == q2_addr)) q2_match = 1'b1;
        end
        q1_hit = !rst && (q1_addr != 5'd0) && (q1_match || (b_valid && (b_waddr == q1_addr)));
        q2_hit = !rst && (q2_addr != 5'd0) && (q2_match || (b_valid && (b_waddr == q2_addr)));
    end

    assign b_ready   = !rst && space;
    assign occupancy = rst ? '0 : count;

`ifdef RF_ARB_AGE_EN
    localparam int AW = $clog2(AGE_LIMIT + 1);

    logic [AW-1:0] age;

    // Counts cycles the valid head is held off by writeback; any pop clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age <= '0;
        end else if (pop) begin
            age <= '0;
        end else if (head_live && (age != AW'(AGE_LIMIT))) begin
            age <= age + AW'(1);
        end
    end

    assign stall_req = !rst && (age == AW'(AGE_LIMIT));
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: doc/regfile_wport_arb.md
# regfile_wport_arb

Write-port arbiter for the 32x32 general-purpose register file. It shares the register file's single write port between two requesters. The pipeline writeback stage has absolute priority and is never back-pressured. A long-latency unit (multiply/divide, miss load) uses a valid/ready handshake and is buffered in a small in-order queue. The block also reports buffered writes still pending to decode-stage read addresses, so hazard logic can stall.

## Interface
Parameters:
- `DEPTH`, 2: queue entries for long-unit writes (power of two, 2..8).
- `AGE_LIMIT`, 8: cycles a valid head may wait before requesting a stall (used only with `RF_ARB_AGE_EN`).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `a_we`  in  1  writeback write request.
- `a_waddr`  in  5  writeback destination register.
- `a_wdata`  in  32  writeback data.
- `b_valid`  in  1  long-unit result valid.
- `b_ready`  out  1  queue can accept a long-unit result.
- `b_waddr`  in  5  long-unit destination register.
- `b_wdata`  in  32  long-unit data.
- `we`  out  1  register file write enable.
- `waddr`  out  5  register file write address.
- `wdata`  out  32  register file write data.
- `q1_addr`, `q2_addr`  in  5 each  decode read addresses.
- `q1_hit`, `q2_hit`  out  1 each  a pending long-unit write targets the query address.
- `stall_req`  out  1  request that the pipeline bubble writeback.
- `occupancy`  out  $clog2(DEPTH)+1  number of queue entries.

## Operation
- Writeback request A is effective when `a_we`=1 and `a_waddr`!=0. A write to r0 is discarded and does not occupy the port.
- Queue: circular buffer of {valid, addr, data} with head and tail pointers and a count. Pointers wrap modulo `DEPTH`.
- Push: a push occurs when `b_valid` and `b_ready` are both 1. `b_ready` = (count < `DEPTH`). It depends only on state and has no combinational path from `a_we`. A push with `b_waddr`=0 is accepted and stored with valid=0.
- Port grant, combinational:
  - If A is effective, then `we`=1 and `waddr`/`wdata` come from A.
  - Otherwise, if the head entry is valid, `we`=1 and the outputs come from the head, which is popped.
  - Otherwise `we`=0 and `waddr`/`wdata` are 0.
- Dead head: if the queue is non-empty and the head is invalid, the head is popped that cycle regardless of A. `we` is not affected by the dead entry.
- WAW kill:
  - An effective A write clears the valid bit of every queued entry whose addr equals `a_waddr`. A long-unit result is program-order older than any writeback in the same or a later cycle.
  - A same-cycle push to the same address is stored with valid=0.
- Hazard query: `qN_hit`=1 when `qN_addr`!=0 and either of these matches `qN_addr`:
  - any valid queued entry (before this cycle's kill/pop), or
  - `b_valid` with its `b_waddr`.
- Push and pop in the same cycle leave count unchanged. A push while full cannot occur, because `b_ready`=0.

## Timing
- The minimum long-unit latency is 1 cycle: an entry pushed in cycle N can reach the port in cycle N+1.
- Writeback latency is 0 cycles: `we`/`waddr`/`wdata` follow A combinationally in the same cycle.
- Reset:
  - Asserting `rst` at any time empties the queue, clears pointers and count, clears the age counter, and discards all entries.
  - While `rst`=1, all outputs are forced to 0, including `b_ready`.
  - In the first cycle after reset release, `b_ready`=1.
- `occupancy`, `b_ready` and `stall_req` are functions of registered state only.

## Configuration
- `RF_ARB_AGE_EN` defined:
  - An age counter increments each cycle in which the head is valid and not granted. It saturates at `AGE_LIMIT`.
  - The counter clears on a head grant or a head pop.
  - `stall_req`=1 while the counter equals `AGE_LIMIT`.
- `RF_ARB_AGE_EN` undefined: no counter is built, `stall_req` is tied to 0, and `AGE_LIMIT` is ignored.

## Test plan
- Empty queue:
  - Stimulus: A writes r5=0x11 in cycle 0. B pushes r6=0x22 in cycle 0 with A idle in cycle 1.
  - Required response: `we` with r5 in cycle 0, then `we` with r6 in cycle 1, and `occupancy` returns to 0.
- Full queue, `DEPTH`=2:
  - Stimulus: push r1 and r2 while A writes r9, r10, r11 continuously.
  - Required response: `b_ready`=0 and `q1_hit` for r1; after A goes idle, r1 is written, then r2, then `b_ready`=1.
- WAW kill:
  - Stimulus: push r7=0xAA, then A writes r7=0xBB in the next cycle.
  - Required response: only 0xBB reaches the port; the dead entry pops without `we`; `q1_hit`(r7) drops afterwards.
- Same-cycle conflict:
  - Stimulus: push r3 and A writes r3 in the same cycle.
  - Required response: the port writes A's data; the queued entry is invalid; there is no later write of r3.
- Reset mid-operation:
  - Stimulus: two entries queued; assert `rst` asynchronously between clock edges.
  - Required response: `we`/`b_ready`/`occupancy` go to 0 immediately; no buffered write appears after release.
- `RF_ARB_AGE_EN` with `AGE_LIMIT`=3:
  - Stimulus: head valid and A active every cycle.
  - Required response: `stall_req`=1 from the 4th cycle; when A drops, the head is granted and `stall_req` returns to 0 the next cycle.
